// File: rtl/register_file_mp.sv
// ----------------------------------------------------------------------------
// register_file_mp
//   Multi-ported register file: XLEN-wide registers, two combinational read
//   ports, two write ports (port B has priority on an address clash),
//   optional same-cycle write-to-read bypass, optional hardwired-zero
//   register 0, and a per-register busy scoreboard used by decode/writeback.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset (clears registers and busy bits)
//   WriteEnable3   write port A enable
//   Address3       write port A address
//   WD3            write port A data
//   WriteEnable4   write port B enable (wins over port A on the same address)
//   Address4       write port B address
//   WD4            write port B data
//   Reserve        mark register ReserveAddr busy
//   ReserveAddr    register to mark busy
//   Address1/2     read port addresses
//   RD1/RD2        read data (combinational)
//   Busy1/Busy2    busy bit of Address1/Address2 (combinational)
// ----------------------------------------------------------------------------
module register_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            WriteEnable3,
    input  logic [AW-1:0]   Address3,
    input  logic [XLEN-1:0] WD3,
    input  logic            WriteEnable4,
    input  logic [AW-1:0]   Address4,
    input  logic [XLEN-1:0] WD4,
    input  logic            Reserve,
    input  logic [AW-1:0]   ReserveAddr,
    input  logic [AW-1:0]   Address1,
    input  logic [AW-1:0]   Address2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            Busy1,
    output logic            Busy2
);

    // Register storage and scoreboard state
    logic [XLEN-1:0] regs_reg  [NREG];
    logic [XLEN-1:0] regs_next [NREG];
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;

    // Per-register next-state: port B beats port A, a new reservation beats
    // the clear caused by a write to the same register.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
            assign regs_next[gi] = '0;
            assign busy_next[gi] = 1'b0;
        end else begin : g_norm
            logic we_a;
            logic we_b;
            logic rsv;
            assign we_a = WriteEnable3 && (Address3 == AW'(gi));
            assign we_b = WriteEnable4 && (Address4 == AW'(gi));
            assign rsv  = Reserve && (ReserveAddr == AW'(gi));
            assign regs_next[gi] = we_b ? WD4 : (we_a ? WD3 : regs_reg[gi]);
            assign busy_next[gi] = rsv ? 1'b1 : ((we_a || we_b) ? 1'b0 : busy_reg[gi]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
            busy_reg <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= regs_next[i];
            end
            busy_reg <= busy_next;
        end
    end

    // Read ports: index 0 -> port 1, index 1 -> port 2
    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_data [2];
    logic [1:0]      rd_busy;

    assign rd_addr[0] = Address1;
    assign rd_addr[1] = Address2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic hit_a;
        logic hit_b;
        logic rsv_hit;
        logic is_zero;
        assign hit_a   = (BYPASS != 0) && WriteEnable3 && (Address3 == rd_addr[gi]);
        assign hit_b   = (BYPASS != 0) && WriteEnable4 && (Address4 == rd_addr[gi]);
        assign rsv_hit = Reserve && (ReserveAddr == rd_addr[gi]);
        assign is_zero = (ZERO_REG != 0) && (rd_addr[gi] == '0);

        assign rd_data[gi] = is_zero ? '0 :
                             hit_b   ? WD4 :
                             hit_a   ? WD3 :
                             regs_reg[rd_addr[gi]];

        // A pending write releases the register this cycle unless a fresh
        // reservation of the same register arrives alongside it.
        assign rd_busy[gi] = is_zero                         ? 1'b0 :
                             ((hit_a || hit_b) && !rsv_hit)  ? 1'b0 :
                             busy_reg[rd_addr[gi]];
    end

    assign RD1   = rd_data[0];
    assign RD2   = rd_data[1];
    assign Busy1 = rd_busy[0];
    assign Busy2 = rd_busy[1];

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            WriteEnable3, WriteEnable4, Reserve;
    logic [AW-1:0]   Address3, Address4, ReserveAddr, Address1, Address2;
    logic [XLEN-1:0] WD3, WD4;
    logic [XLEN-1:0] RD1, RD2, nb_RD1, nb_RD2;
    logic            Busy1, Busy2, nb_Busy1, nb_Busy2;

    always #5 clk = ~clk;

    register_file_mp #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .WriteEnable3(WriteEnable3), .Address3(Address3), .WD3(WD3),
        .WriteEnable4(WriteEnable4), .Address4(Address4), .WD4(WD4),
        .Reserve(Reserve), .ReserveAddr(ReserveAddr),
        .Address1(Address1), .Address2(Address2),
        .RD1(RD1), .RD2(RD2), .Busy1(Busy1), .Busy2(Busy2)
    );

    // Same stimulus, no bypass
    register_file_mp #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst(rst),
        .WriteEnable3(WriteEnable3), .Address3(Address3), .WD3(WD3),
        .WriteEnable4(WriteEnable4), .Address4(Address4), .WD4(WD4),
        .Reserve(Reserve), .ReserveAddr(ReserveAddr),
        .Address1(Address1), .Address2(Address2),
        .RD1(nb_RD1), .RD2(nb_RD2), .Busy1(nb_Busy1), .Busy2(nb_Busy2)
    );

    // Observed signal selectors
    localparam int S_RD1 = 0, S_RD2 = 1, S_B1 = 2, S_B2 = 3, S_NB_RD1 = 4, S_NB_B1 = 5;

    typedef struct {
        string           tag;
        int              sig;
        logic [XLEN-1:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic expect_val(input string tag, input int sig, input logic [XLEN-1:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    function automatic logic [XLEN-1:0] observe(input int sig);
        case (sig)
            S_RD1:    return RD1;
            S_RD2:    return RD2;
            S_B1:     return {31'b0, Busy1};
            S_B2:     return {31'b0, Busy2};
            S_NB_RD1: return nb_RD1;
            S_NB_B1:  return {31'b0, nb_Busy1};
            default:  return 'x;
        endcase
    endfunction

    // Let combinational outputs settle, then pop and compare every queued expectation
    task automatic drain();
        exp_t            e;
        logic [XLEN-1:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            n_tests++;
            $display("[TB] check %s: observed %h expected %h", e.tag, obs, e.val);
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WriteEnable3 = 1'b0;
        WriteEnable4 = 1'b0;
        Reserve      = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        Address3 = '0; Address4 = '0; ReserveAddr = '0;
        Address1 = '0; Address2 = '0;
        WD3 = '0; WD4 = '0;
        tick();
        tick();
        rst = 1'b0;

        // 1: reset clears stored data
        WriteEnable3 = 1'b1; Address3 = 5'd5;  WD3 = 32'hAAAAAAAA;
        WriteEnable4 = 1'b1; Address4 = 5'd10; WD4 = 32'hBBBBBBBB;
        tick();
        idle();
        Address1 = 5'd5; Address2 = 5'd10;
        expect_val("pre_rst_rd1", S_RD1, 32'hAAAAAAAA);
        expect_val("pre_rst_rd2", S_RD2, 32'hBBBBBBBB);
        drain();
        rst = 1'b1;
        tick();
        expect_val("rst_rd1", S_RD1, 32'h0);
        expect_val("rst_rd2", S_RD2, 32'h0);
        expect_val("rst_busy1", S_B1, 32'h0);
        expect_val("rst_busy2", S_B2, 32'h0);
        drain();
        rst = 1'b0;
        tick();
        expect_val("post_rst_rd1", S_RD1, 32'h0);
        expect_val("post_rst_rd2", S_RD2, 32'h0);
        drain();

        // 2: dual write, distinct and same address
        WriteEnable3 = 1'b1; Address3 = 5'd3; WD3 = 32'h11111111;
        WriteEnable4 = 1'b1; Address4 = 5'd4; WD4 = 32'h22222222;
        tick();
        idle();
        Address1 = 5'd3; Address2 = 5'd4;
        expect_val("dual_rd1", S_RD1, 32'h11111111);
        expect_val("dual_rd2", S_RD2, 32'h22222222);
        drain();
        WriteEnable3 = 1'b1; Address3 = 5'd7; WD3 = 32'h33333333;
        WriteEnable4 = 1'b1; Address4 = 5'd7; WD4 = 32'h44444444;
        Address1 = 5'd7;
        expect_val("same_bypass_rd1", S_RD1, 32'h44444444);
        drain();
        tick();
        idle();
        expect_val("same_rd1", S_RD1, 32'h44444444);
        expect_val("same_nb_rd1", S_NB_RD1, 32'h44444444);
        drain();

        // 3: zero register
        WriteEnable3 = 1'b1; Address3 = 5'd0; WD3 = 32'hFFFFFFFF;
        Reserve = 1'b1; ReserveAddr = 5'd0;
        Address1 = 5'd0;
        expect_val("zero_wr_rd1", S_RD1, 32'h0);
        expect_val("zero_wr_busy1", S_B1, 32'h0);
        drain();
        tick();
        idle();
        expect_val("zero_rd1", S_RD1, 32'h0);
        expect_val("zero_busy1", S_B1, 32'h0);
        expect_val("zero_nb_busy1", S_NB_B1, 32'h0);
        drain();

        // 4: bypass vs no bypass
        WriteEnable3 = 1'b1; Address3 = 5'd9; WD3 = 32'hDEADBEEF;
        Address1 = 5'd9;
        expect_val("byp_rd1", S_RD1, 32'hDEADBEEF);
        expect_val("nobyp_rd1", S_NB_RD1, 32'h0);
        drain();
        tick();
        idle();
        expect_val("byp_after_rd1", S_RD1, 32'hDEADBEEF);
        expect_val("nobyp_after_rd1", S_NB_RD1, 32'hDEADBEEF);
        drain();

        // 5: scoreboard
        Reserve = 1'b1; ReserveAddr = 5'd12;
        Address1 = 5'd12; Address2 = 5'd13;
        expect_val("rsv_pre_busy1", S_B1, 32'h0);
        drain();
        tick();
        idle();
        expect_val("rsv_busy1", S_B1, 32'h1);
        expect_val("rsv_other_busy2", S_B2, 32'h0);
        expect_val("rsv_nb_busy1", S_NB_B1, 32'h1);
        drain();
        WriteEnable3 = 1'b1; Address3 = 5'd12; WD3 = 32'hCAFEF00D;
        expect_val("clr_comb_busy1", S_B1, 32'h0);
        expect_val("clr_comb_nb_busy1", S_NB_B1, 32'h1);
        drain();
        tick();
        idle();
        expect_val("clr_busy1", S_B1, 32'h0);
        expect_val("clr_rd1", S_RD1, 32'hCAFEF00D);
        drain();
        Reserve = 1'b1; ReserveAddr = 5'd12;
        WriteEnable4 = 1'b1; Address4 = 5'd12; WD4 = 32'h5555AAAA;
        expect_val("rsvwr_comb_busy1", S_B1, 32'h0);
        drain();
        tick();
        idle();
        expect_val("rsvwr_busy1", S_B1, 32'h1);
        expect_val("rsvwr_rd1", S_RD1, 32'h5555AAAA);
        drain();

        // 6: reset discards same-cycle reserve and write
        Address1 = 5'd6; Address2 = 5'd12;
        rst = 1'b1;
        Reserve = 1'b1; ReserveAddr = 5'd6;
        WriteEnable3 = 1'b1; Address3 = 5'd6; WD3 = 32'h12345678;
        tick();
        rst = 1'b0;
        idle();
        expect_val("rstact_rd1", S_RD1, 32'h0);
        expect_val("rstact_busy1", S_B1, 32'h0);
        expect_val("rstact_busy2_r12", S_B2, 32'h0);
        expect_val("rstact_rd2_r12", S_RD2, 32'h0);
        drain();
        tick();
        expect_val("rstact_after_rd1", S_RD1, 32'h0);
        expect_val("rstact_after_busy1", S_B1, 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
